gb_board_ctrl: RTL and testbench
================================

# gb_board_ctrl

Parametrised game-board store and controller for the Tetris datapath. It holds a ROWS×COLS grid of CELL_W-bit cells. It executes piece commands (stamp, erase, collision check, single-cell write) against a 4×4 piece mask, and runs a multi-cycle line-clear sequencer that removes every full row and compacts the board. It sits between the game-logic CPU instruction decoder (command side) and the display/row-readback logic (read side).

## Interface
Parameters:
- COLS, 10, board width in cells
- ROWS, 20, board height in rows; row 0 is the bottom
- CELL_W, 3, bits per cell; value 0 means empty
- ROW_AW, 5, row index width (≥ clog2(ROWS))
- COL_AW, 4, column index width (≥ clog2(COLS))
- LINE_W, 5, width of cleared-line count (≥ clog2(ROWS+1))
- RESET_CELL, 0, value loaded into every cell at reset

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle and able to accept
- cmd_op  in  3  0 WRITE, 1 STAMP, 2 ERASE, 3 CHECK, 4 CLEAR, 5–7 NOP
- cmd_x  in  COL_AW  anchor column (mask dx=0)
- cmd_y  in  ROW_AW  anchor row (mask dy=0)
- cmd_mask  in  16  piece mask; bit dy*4+dx covers cell (cmd_x+dx, cmd_y+dy)
- cmd_data  in  CELL_W  cell value for WRITE/STAMP
- rsp_valid  out  1  one-cycle completion pulse
- rsp_collide  out  1  collision/out-of-range flag
- rsp_lines  out  LINE_W  rows removed by CLEAR
- rd_row  in  ROW_AW  readback row select
- rd_data  out  COLS*CELL_W  cells of rd_row; column 0 in the LSBs; 0 if rd_row ≥ ROWS
- rd_occ  out  COLS  per-column occupancy (cell ≠ 0) of rd_row
- full_rows  out  ROWS  bit r set when every cell of row r is nonzero

## Operation
- FSM states: IDLE, EXEC, SCAN, RESP. cmd_ready = (state==IDLE). A command is accepted on cmd_valid && cmd_ready, and its operands are latched.
- IDLE → EXEC for ops 0–3 and NOP. IDLE → SCAN for CLEAR, with scan pointer r=0 and line count=0.
- EXEC (one cycle; the board updates at its closing edge, then the FSM moves to RESP):
  - WRITE: writes cell (cmd_x, cmd_y) = cmd_data if in range; otherwise no write and collide=1.
  - STAMP: each set mask bit whose cell is in range gets cmd_data. Out-of-range bits are not written. collide is computed on the pre-write board.
  - ERASE: each set in-range mask cell becomes 0. collide=0.
  - CHECK: no write. collide = any set mask bit with column ≥ COLS, row ≥ ROWS, or target cell nonzero.
  - STAMP uses the same collide rule as CHECK.
  - NOP: no write. collide=0.
- SCAN (one row per cycle):
  - If row r is full: rows r..ROWS-2 take rows r+1..ROWS-1, row ROWS-1 becomes all 0, count increments, and r is unchanged so the shifted-in row is rescanned.
  - Otherwise r increments.
  - When r reaches ROWS, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle with rsp_collide and rsp_lines (the CLEAR count; 0 for other ops), then go to IDLE.
- rsp_collide and rsp_lines hold their values until the next RESP.
- rd_data, rd_occ and full_rows are combinational from the registered board, so intermediate boards are visible during SCAN.
- cmd_valid is ignored while not in IDLE. A held request is accepted on return to IDLE.
- Coordinate arithmetic is done at COL_AW+2 / ROW_AW+2 bits so that cmd_x+3 and cmd_y+3 never wrap.

## Timing
- Reset values:
  - State IDLE, cmd_ready=1, rsp_valid=0, rsp_collide=0, rsp_lines=0.
  - All cells RESET_CELL; full_rows all 1 if RESET_CELL≠0, else 0.
- Reset asserted mid-command aborts immediately. No rsp_valid is issued, and the board returns to its reset contents.
- WRITE/STAMP/ERASE/CHECK/NOP:
  - Accept at edge 0.
  - Board updates at edge 1.
  - rsp_valid is high between edges 1 and 2.
  - cmd_ready returns at edge 2.
  - Throughput is one command per 3 cycles.
- CLEAR: with k full rows, SCAN lasts ROWS+k cycles. rsp_valid follows in the next cycle, so total latency from accept to rsp_valid is ROWS+k+1 edges.
- Full rows must be strictly cell-nonzero; a row of all-zero cells is never cleared.

## Test plan
- Reset with RESET_CELL=0 → all rd_data 0, full_rows=0, cmd_ready=1, rsp_valid=0.
- STAMP x=4, y=0, mask=0x0033 (square), data=2 → rd_data row0/row1 cols 4,5 =2, rsp_collide=0, rsp_valid exactly 2 cycles after accept; repeat the STAMP → rsp_collide=1.
- CHECK x=8, y=0, mask=0x000F (horizontal line) on an empty board → rsp_collide=1 (cols 10,11 out of range), board unchanged; ERASE of the earlier square → rows 0–1 empty.
- Fill rows 0 and 1 with WRITE, put value 5 at row 2 col 3, then CLEAR → rsp_lines=2, row0 col3=5, rows 1–19 empty, rsp_valid ROWS+3 cycles after accept.
- CLEAR on a board with no full rows → rsp_lines=0, latency ROWS+1; cmd_valid held during SCAN is accepted only after rsp_valid.
- Assert rst_n low at SCAN cycle 5 of a CLEAR → no rsp_valid, board at reset values, cmd_ready=1 when released.

Source files
------------

// File: rtl/gb_board_ctrl.sv
// Tetris board store: piece stamp/erase/check/write commands and a row-by-row line-clear sequencer.
// Commands answer 2 cycles after accept; CLEAR answers ROWS+k+1 cycles after accept, where k is the number of cleared rows.
module gb_board_ctrl #(
    parameter int COLS       = 10,
    parameter int ROWS       = 20,
    parameter int CELL_W     = 3,
    parameter int ROW_AW     = 5,
    parameter int COL_AW     = 4,
    parameter int LINE_W     = 5,
    parameter int RESET_CELL = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [COL_AW-1:0]      cmd_x,
    input  logic [ROW_AW-1:0]      cmd_y,
    input  logic [15:0]            cmd_mask,
    input  logic [CELL_W-1:0]      cmd_data,
    output logic                   rsp_valid,
    output logic                   rsp_collide,
    output logic [LINE_W-1:0]      rsp_lines,
    input  logic [ROW_AW-1:0]      rd_row,
    output logic [COLS*CELL_W-1:0] rd_data,
    output logic [COLS-1:0]        rd_occ,
    output logic [ROWS-1:0]        full_rows
);
    typedef enum logic [1:0] {IDLE, EXEC, SCAN, RESP} state_t;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_STAMP = 3'd1;
    localparam logic [2:0] OP_ERASE = 3'd2;
    localparam logic [2:0] OP_CHECK = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    localparam logic [CELL_W-1:0] RST_C    = CELL_W'(RESET_CELL);
    localparam logic [COL_AW+1:0] COLS_W   = (COL_AW+2)'(COLS);
    localparam logic [ROW_AW+1:0] ROWS_W   = (ROW_AW+2)'(ROWS);
    localparam logic [ROW_AW:0]   ROWS_RD  = (ROW_AW+1)'(ROWS);
    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS-1);

    state_t              state_q, state_d;
    logic [CELL_W-1:0]   board   [ROWS][COLS];
    logic [CELL_W-1:0]   board_d [ROWS][COLS];
    logic [2:0]          op_q;
    logic [COL_AW-1:0]   x_q;
    logic [ROW_AW-1:0]   y_q;
    logic [15:0]         mask_q;
    logic [CELL_W-1:0]   data_q;
    logic [ROW_AW-1:0]   scan_r;
    logic [LINE_W-1:0]   lines_q;
    logic                accept, hit, collide_d;

    // Widened piece coordinates so anchor+3 never wraps back into range.
    logic [COL_AW+1:0]   tx [4];
    logic [ROW_AW+1:0]   ty [4];
    logic [3:0]          tx_ok, ty_ok;

    for (genvar d = 0; d < 4; d++) begin : g_coord
        assign tx[d]    = {2'b00, x_q} + (COL_AW+2)'(d);
        assign ty[d]    = {2'b00, y_q} + (ROW_AW+2)'(d);
        assign tx_ok[d] = tx[d] < COLS_W;
        assign ty_ok[d] = ty[d] < ROWS_W;
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);

    always_comb begin
        hit = 1'b0;
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                if (mask_q[dy*4+dx]) begin
                    if (!(tx_ok[dx] && ty_ok[dy]))
                        hit = 1'b1;
                    else if (board[ty[dy][ROW_AW-1:0]][tx[dx][COL_AW-1:0]] != '0)
                        hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            full_rows[r] = 1'b1;
            for (int c = 0; c < COLS; c++)
                if (board[r][c] == '0) full_rows[r] = 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_occ  = '0;
        if ({1'b0, rd_row} < ROWS_RD) begin
            for (int c = 0; c < COLS; c++) begin
                rd_data[c*CELL_W +: CELL_W] = board[rd_row][c];
                rd_occ[c]                   = |board[rd_row][c];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board;
        collide_d = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = (cmd_op == OP_CLEAR) ? SCAN : EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
                case (op_q)
                    OP_WRITE: begin
                        if (tx_ok[0] && ty_ok[0])
                            board_d[ty[0][ROW_AW-1:0]][tx[0][COL_AW-1:0]] = data_q;
                        else
                            collide_d = 1'b1;
                    end
                    OP_STAMP, OP_ERASE: begin
                        for (int dy = 0; dy < 4; dy++)
                            for (int dx = 0; dx < 4; dx++)
                                if (mask_q[dy*4+dx] && tx_ok[dx] && ty_ok[dy])
                                    board_d[ty[dy][ROW_AW-1:0]][tx[dx][COL_AW-1:0]] =
                                        (op_q == OP_STAMP) ? data_q : '0;
                        collide_d = (op_q == OP_STAMP) && hit;
                    end
                    OP_CHECK: collide_d = hit;
                    default: ;
                endcase
            end
            SCAN: begin
                // Pointer holds on a cleared row so the row shifted down is rescanned.
                if (full_rows[scan_r]) begin
                    for (int i = 0; i < ROWS-1; i++)
                        if (ROW_AW'(i) >= scan_r) board_d[i] = board[i+1];
                    board_d[ROWS-1] = '{default: '0};
                end else if (scan_r == LAST_ROW) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            scan_r      <= '0;
            lines_q     <= '0;
            rsp_collide <= 1'b0;
            rsp_lines   <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board[r][c] <= RST_C;
        end else begin
            state_q <= state_d;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board[r][c] <= board_d[r][c];
            if (accept) begin
                op_q    <= cmd_op;
                x_q     <= cmd_x;
                y_q     <= cmd_y;
                mask_q  <= cmd_mask;
                data_q  <= cmd_data;
                scan_r  <= '0;
                lines_q <= '0;
            end
            if (state_q == SCAN) begin
                if (full_rows[scan_r]) lines_q <= lines_q + 1'b1;
                else                   scan_r  <= scan_r + 1'b1;
            end
            if (state_q == EXEC) begin
                rsp_collide <= collide_d;
                rsp_lines   <= '0;
            end
            if (state_q == SCAN && state_d == RESP) begin
                rsp_collide <= 1'b0;
                rsp_lines   <= lines_q;
            end
        end
    end
endmodule

// File: tb/tb_gb_board_ctrl.sv
// Directed bench for gb_board_ctrl: piece commands, out-of-range handling, line clear and reset abort.
module tb_gb_board_ctrl;
    localparam int COLS = 10, ROWS = 20, CELL_W = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [2:0]             cmd_op = '0;
    logic [3:0]             cmd_x = '0;
    logic [4:0]             cmd_y = '0;
    logic [15:0]            cmd_mask = '0;
    logic [CELL_W-1:0]      cmd_data = '0;
    logic                   rsp_valid, rsp_collide;
    logic [4:0]             rsp_lines;
    logic [4:0]             rd_row = '0;
    logic [COLS*CELL_W-1:0] rd_data;
    logic [COLS-1:0]        rd_occ;
    logic [ROWS-1:0]        full_rows;

    int n_checks = 0, n_fail = 0;

    gb_board_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_mask(cmd_mask),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_collide(rsp_collide),
        .rsp_lines(rsp_lines), .rd_row(rd_row), .rd_data(rd_data), .rd_occ(rd_occ),
        .full_rows(full_rows)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic read_row(input int r, output logic [COLS*CELL_W-1:0] d);
        rd_row = 5'(r);
        #1;
        d = rd_data;
    endtask

    // OR of every row in [lo, hi]; zero means those rows are empty.
    task automatic rows_or(input int lo, input int hi, output logic [COLS*CELL_W-1:0] acc);
        logic [COLS*CELL_W-1:0] d;
        acc = '0;
        for (int r = lo; r <= hi; r++) begin
            read_row(r, d);
            acc |= d;
        end
    endtask

    // Issue one command from a negedge; returns negedges from accept until rsp_valid (-1 on timeout).
    task automatic do_cmd(input logic [2:0] op, input int x, input int y, input logic [15:0] m,
                          input logic [2:0] d, output int lat);
        int n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_x = 4'(x); cmd_y = 5'(y); cmd_mask = m; cmd_data = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin
            check("rsp_timeout", 64'(lat), 64'd0);
            lat = -1;
        end
    endtask

    logic [COLS*CELL_W-1:0] d, exp_row;
    int lat, n, ready_hi, vld_hi;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset_ready", 64'(cmd_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_collide", 64'(rsp_collide), 64'd0);
        check("reset_lines", 64'(rsp_lines), 64'd0);
        check("reset_full_rows", 64'(full_rows), 64'd0);
        rows_or(0, ROWS-1, d);
        check("reset_board", 64'(d), 64'd0);
        read_row(ROWS, d);
        check("rd_out_of_range", 64'(d), 64'd0);

        // Square at cols 4,5 of rows 0,1
        do_cmd(3'd1, 4, 0, 16'h0033, 3'd2, lat);
        check("stamp_latency", 64'(lat), 64'd2);
        check("stamp_collide", 64'(rsp_collide), 64'd0);
        read_row(0, d);
        check("stamp_row0", 64'(d), 64'h12000);
        check("stamp_occ0", 64'(rd_occ), 64'h030);
        read_row(1, d);
        check("stamp_row1", 64'(d), 64'h12000);
        do_cmd(3'd1, 4, 0, 16'h0033, 3'd2, lat);
        check("restamp_collide", 64'(rsp_collide), 64'd1);

        do_cmd(3'd3, 8, 0, 16'h000F, 3'd0, lat);
        check("check_oor_collide", 64'(rsp_collide), 64'd1);
        repeat (3) @(negedge clk);
        check("collide_hold", 64'(rsp_collide), 64'd1);
        read_row(0, d);
        check("check_no_write", 64'(d), 64'h12000);
        do_cmd(3'd3, 0, 17, 16'h1000, 3'd0, lat);
        check("check_row_oor", 64'(rsp_collide), 64'd1);
        do_cmd(3'd3, 0, 0, 16'h0033, 3'd0, lat);
        check("check_free", 64'(rsp_collide), 64'd0);
        do_cmd(3'd0, 10, 0, 16'h0000, 3'd7, lat);
        check("write_oor_collide", 64'(rsp_collide), 64'd1);

        do_cmd(3'd2, 4, 0, 16'h0033, 3'd0, lat);
        check("erase_collide", 64'(rsp_collide), 64'd0);
        rows_or(0, 1, d);
        check("erase_rows01", 64'(d), 64'd0);

        // Fill rows 0 and 1, one marker cell in row 2
        exp_row = '0;
        for (int y = 0; y < 2; y++)
            for (int c = 0; c < COLS; c++)
                do_cmd(3'd0, c, y, 16'h0000, 3'(c % 7 + 1), lat);
        for (int c = 0; c < COLS; c++) exp_row |= (COLS*CELL_W)'(c % 7 + 1) << (3*c);
        read_row(1, d);
        check("fill_row1", 64'(d), 64'(exp_row));
        do_cmd(3'd0, 3, 2, 16'h0000, 3'd5, lat);
        check("write_collide", 64'(rsp_collide), 64'd0);
        check("full_rows_pre", 64'(full_rows), 64'h3);

        do_cmd(3'd4, 0, 0, 16'h0000, 3'd0, lat);
        check("clear2_latency", 64'(lat), 64'(ROWS+3));
        check("clear2_lines", 64'(rsp_lines), 64'd2);
        read_row(0, d);
        check("clear2_row0", 64'(d), 64'hA00);
        rows_or(1, ROWS-1, d);
        check("clear2_upper_empty", 64'(d), 64'd0);
        check("clear2_full_rows", 64'(full_rows), 64'd0);
        repeat (4) @(negedge clk);
        check("lines_hold", 64'(rsp_lines), 64'd2);

        // CLEAR with no full rows while a NOP request is held throughout the scan
        cmd_valid = 1'b1; cmd_op = 3'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 3'd5;
        lat = 1; ready_hi = 0;
        while (!rsp_valid && lat < 100) begin
            if (cmd_ready) ready_hi++;
            @(negedge clk); lat++;
        end
        check("clear0_latency", 64'(lat), 64'(ROWS+1));
        check("clear0_lines", 64'(rsp_lines), 64'd0);
        check("ready_during_scan", 64'(ready_hi), 64'd0);
        n = 0;
        while (n < 10) begin
            @(negedge clk); n++;
            if (!cmd_ready) cmd_valid = 1'b0;
            if (rsp_valid) break;
        end
        cmd_valid = 1'b0;
        check("held_nop_rsp_delay", 64'(n), 64'd3);
        check("nop_lines", 64'(rsp_lines), 64'd0);
        read_row(0, d);
        check("clear0_row0", 64'(d), 64'hA00);

        // Reset during SCAN cycle 5
        do_cmd(3'd0, 0, 5, 16'h0000, 3'd3, lat);
        cmd_valid = 1'b1; cmd_op = 3'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        vld_hi = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid) vld_hi++; end
        rst_n = 1'b1;
        repeat (30) begin @(negedge clk); if (rsp_valid) vld_hi++; end
        check("abort_no_rsp", 64'(vld_hi), 64'd0);
        check("abort_ready", 64'(cmd_ready), 64'd1);
        rows_or(0, ROWS-1, d);
        check("abort_board_reset", 64'(d), 64'd0);
        check("abort_lines", 64'(rsp_lines), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
